// File: rtl/hamming74_codec.sv
// Hamming(7,4) SEC codec: independent registered encoder and decoder, plus a saturating corrected-word counter.
// Latency: one cycle on each path (strobe in at an edge, result and strobe out registered at that edge).
// Backpressure: none; every strobed word is accepted, and the outputs hold their last value while idle.
module hamming74_codec #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_valid,
    input  logic [3:0]       data,
    output logic             encoded_valid,
    output logic [6:0]       encoded_data,
    input  logic             received_valid,
    input  logic [6:0]       received_data,
    output logic             decoded_valid,
    output logic [3:0]       decoded_data,
    output logic [2:0]       syndrome,
    output logic             error_detected,
    output logic [CNT_W-1:0] err_count,
    input  logic             err_count_clr
);

    logic [6:0] code_c;
    logic [2:0] syn_c;
    logic [6:0] flip_c;
    logic [6:0] corr_c;

    // Codeword layout {d3,d2,d1,p4,d0,p2,p1}, even parity; bit i is code position i+1.
    always_comb begin
        code_c[0] = data[0] ^ data[1] ^ data[3];
        code_c[1] = data[0] ^ data[2] ^ data[3];
        code_c[2] = data[0];
        code_c[3] = data[1] ^ data[2] ^ data[3];
        code_c[4] = data[1];
        code_c[5] = data[2];
        code_c[6] = data[3];
    end

    // Syndrome is the 1-based position of the flipped bit; flip that bit back when nonzero.
    always_comb begin
        syn_c[0] = received_data[0] ^ received_data[2] ^ received_data[4] ^ received_data[6];
        syn_c[1] = received_data[1] ^ received_data[2] ^ received_data[5] ^ received_data[6];
        syn_c[2] = received_data[3] ^ received_data[4] ^ received_data[5] ^ received_data[6];
        flip_c   = '0;
        if (syn_c != 3'd0) begin
            flip_c = 7'd1 << (syn_c - 3'd1);
        end
        corr_c = received_data ^ flip_c;
    end

    // Encoder output register: strobe follows data_valid, payload holds while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            encoded_valid <= 1'b0;
            encoded_data  <= '0;
        end else begin
            encoded_valid <= data_valid;
            if (data_valid) begin
                encoded_data <= code_c;
            end
        end
    end

    // Decoder output register: data, syndrome and flag update together on an accepted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decoded_valid  <= 1'b0;
            decoded_data   <= '0;
            syndrome       <= '0;
            error_detected <= 1'b0;
        end else begin
            decoded_valid <= received_valid;
            if (received_valid) begin
                decoded_data   <= {corr_c[6], corr_c[5], corr_c[4], corr_c[2]};
                syndrome       <= syn_c;
                error_detected <= (syn_c != 3'd0);
            end
        end
    end

    // Corrected-word counter: clear wins over increment, and it sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (err_count_clr) begin
            err_count <= '0;
        end else if (received_valid && (syn_c != 3'd0) && (err_count != {CNT_W{1'b1}})) begin
            err_count <= err_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hamming74_codec.sv
module tb_hamming74_codec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        data_valid;
    logic [3:0]  data;
    logic        encoded_valid;
    logic [6:0]  encoded_data;
    logic        received_valid;
    logic [6:0]  received_data;
    logic        decoded_valid;
    logic [3:0]  decoded_data;
    logic [2:0]  syndrome;
    logic        error_detected;
    logic [15:0] err_count;
    logic        err_count_clr;

    // Narrow-counter instance used for the saturation test.
    logic        s_enc_valid;
    logic [6:0]  s_enc_data;
    logic        s_rx_valid;
    logic [6:0]  s_rx_data;
    logic        s_dec_valid;
    logic [3:0]  s_dec_data;
    logic [2:0]  s_syn;
    logic        s_err;
    logic [1:0]  s_cnt;
    logic        s_clr;

    int checks = 0;
    int errors = 0;

    // Hand-computed codewords for d = 0..15.
    logic [6:0] cw [16] = '{7'h00, 7'h07, 7'h19, 7'h1E, 7'h2A, 7'h2D, 7'h33, 7'h34,
                            7'h4B, 7'h4C, 7'h52, 7'h55, 7'h61, 7'h66, 7'h78, 7'h7F};

    always #5 clk = ~clk;

    hamming74_codec #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .data_valid(data_valid), .data(data),
        .encoded_valid(encoded_valid), .encoded_data(encoded_data),
        .received_valid(received_valid), .received_data(received_data),
        .decoded_valid(decoded_valid), .decoded_data(decoded_data),
        .syndrome(syndrome), .error_detected(error_detected),
        .err_count(err_count), .err_count_clr(err_count_clr)
    );

    hamming74_codec #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .data_valid(1'b0), .data(4'd0),
        .encoded_valid(s_enc_valid), .encoded_data(s_enc_data),
        .received_valid(s_rx_valid), .received_data(s_rx_data),
        .decoded_valid(s_dec_valid), .decoded_data(s_dec_data),
        .syndrome(s_syn), .error_detected(s_err),
        .err_count(s_cnt), .err_count_clr(s_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " enc_vld"}, 32'(encoded_valid), 0);
        check({tag, " enc_dat"}, 32'(encoded_data), 0);
        check({tag, " dec_vld"}, 32'(decoded_valid), 0);
        check({tag, " dec_dat"}, 32'(decoded_data), 0);
        check({tag, " syn"},     32'(syndrome), 0);
        check({tag, " err"},     32'(error_detected), 0);
        check({tag, " cnt"},     32'(err_count), 0);
        check({tag, " sat_cnt"}, 32'(s_cnt), 0);
    endtask

    task automatic check_dec(input string tag, input logic [3:0] d, input logic [2:0] s, input logic [15:0] cnt);
        check({tag, " vld"}, 32'(decoded_valid), 1);
        check({tag, " dat"}, 32'(decoded_data), 32'(d));
        check({tag, " syn"}, 32'(syndrome), 32'(s));
        check({tag, " err"}, 32'(error_detected), 32'(s != 3'd0));
        check({tag, " cnt"}, 32'(err_count), 32'(cnt));
    endtask

    initial begin
        rst_n = 1'b0; data_valid = 1'b0; data = '0; received_valid = 1'b0; received_data = '0;
        err_count_clr = 1'b0; s_rx_valid = 1'b0; s_rx_data = '0; s_clr = 1'b0;
        #2;
        check_all_zero("reset");
        step();
        rst_n = 1'b1;
        step();

        // Encode 1010.
        data_valid = 1'b1; data = 4'b1010;
        step();
        check("enc 1010 vld", 32'(encoded_valid), 1);
        check("enc 1010 dat", 32'(encoded_data), 32'h52);
        data_valid = 1'b0; data = 4'b0101;
        step();
        check("enc idle vld", 32'(encoded_valid), 0);
        check("enc idle hold", 32'(encoded_data), 32'h52);

        // Clean and single-bit-error decodes.
        received_valid = 1'b1; received_data = 7'b1010010;
        step();
        check_dec("dec clean", 4'b1010, 3'd0, 16'd0);
        received_data = 7'b1010011;
        step();
        check_dec("dec bit0", 4'b1010, 3'd1, 16'd1);
        received_data = 7'b1010000;
        step();
        check_dec("dec bit1", 4'b1010, 3'd2, 16'd2);
        received_data = 7'b1010110;
        step();
        check_dec("dec bit2", 4'b1010, 3'd3, 16'd3);

        // Decoder idle holds everything except the strobe.
        received_valid = 1'b0; received_data = 7'b0000001;
        step();
        check("dec idle vld", 32'(decoded_valid), 0);
        check("dec idle dat", 32'(decoded_data), 32'hA);
        check("dec idle syn", 32'(syndrome), 3);
        check("dec idle err", 32'(error_detected), 1);
        check("dec idle cnt", 32'(err_count), 3);

        // Double-bit error is miscorrected: bits 0 and 1 flipped gives syndrome 3, flips bit 2.
        received_valid = 1'b1; received_data = 7'b1010001;
        step();
        check_dec("dec double", 4'b1011, 3'd3, 16'd4);

        // Full sweep, encoder and decoder strobed in the same cycle.
        data_valid = 1'b1;
        for (int d = 0; d < 16; d++) begin
            for (int e = 0; e < 8; e++) begin
                data = 4'(d);
                received_data = cw[d] ^ ((e == 0) ? 7'd0 : (7'd1 << (e - 1)));
                step();
                check("sweep enc", 32'(encoded_data), 32'(cw[d]));
                check("sweep enc vld", 32'(encoded_valid), 1);
                check("sweep dec", 32'(decoded_data), 32'(d));
                check("sweep syn", 32'(syndrome), 32'(e));
                check("sweep err", 32'(error_detected), 32'(e != 0));
            end
        end
        data_valid = 1'b0;
        received_valid = 1'b0;
        step();
        check("cnt after sweep", 32'(err_count), 4 + 16 * 7);

        // Clear wins over a simultaneous errored word.
        received_valid = 1'b1; received_data = 7'b1010011; err_count_clr = 1'b1;
        step();
        check("clr+err cnt", 32'(err_count), 0);
        check("clr+err dec", 32'(decoded_data), 32'hA);
        err_count_clr = 1'b0;
        step();
        check("cnt after clr", 32'(err_count), 1);
        received_valid = 1'b0;

        // Two-bit counter saturates at 3.
        s_rx_valid = 1'b1; s_rx_data = 7'b1111110;
        for (int k = 1; k <= 5; k++) begin
            step();
            check("sat cnt", 32'(s_cnt), (k < 3) ? k : 3);
            check("sat dec", 32'(s_dec_data), 32'hF);
        end
        s_clr = 1'b1;
        step();
        check("sat clr", 32'(s_cnt), 0);
        s_clr = 1'b0; s_rx_valid = 1'b0;

        // Reset in the middle of traffic clears outputs without waiting for an edge.
        data_valid = 1'b1; data = 4'b1111; received_valid = 1'b1; received_data = 7'b1111110;
        step();
        check("pre-rst enc vld", 32'(encoded_valid), 1);
        check("pre-rst dec vld", 32'(decoded_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid rst");
        step();
        check("rst held enc vld", 32'(encoded_valid), 0);
        check("rst held dec vld", 32'(decoded_valid), 0);
        data_valid = 1'b0; received_valid = 1'b0;
        rst_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
